// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared types for the CPU run controller (state encoding, trace entry layout).
// The trace entry layout matters only when CPU_TRACE_EN is defined.
package cpu_run_pkg;

  localparam int TR_ADDR_W = 8;
  localparam int TR_DATA_W = 16;
  localparam int CYCLE_W   = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RST     = 3'd1,
    RUN     = 3'd2,
    HALTED  = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  // Field order matches the flat {ip, ir, ac, we} trace word, ip in the MSBs.
  typedef struct packed {
    logic [TR_ADDR_W-1:0] ip;
    logic [TR_DATA_W-1:0] ir;
    logic [TR_DATA_W-1:0] ac;
    logic                 we;
  } trace_entry_t;

endpackage

// File: rtl/cpu_run_ctrl_trace_fifo.sv
// trace_fifo: synchronous FIFO with extra-MSB pointers and a synchronous clear.
// Only built when CPU_TRACE_EN is defined, since nothing else instantiates it.
`ifdef CPU_TRACE_EN
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 41
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the head slot this edge, so a push into a full FIFO is legal then.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clr) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule
`endif

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: holds the CPU in reset, runs it until halt or watchdog expiry, and traces retires.
// Define CPU_TRACE_EN to build the trace FIFO; otherwise trace outputs are tied to zero.
module cpu_run_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int TRACE_DEPTH    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       cpu_reset,
  input  logic [ADDR_W-1:0]          cpu_ip,
  input  logic [DATA_W-1:0]          cpu_ir,
  input  logic [DATA_W-1:0]          cpu_ac,
  input  logic                       cpu_we,
  input  logic                       cpu_retire,
  input  logic                       cpu_halt,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [ADDR_W+2*DATA_W:0]   trace_data,
  output logic                       trace_ovf,
  output logic                       running,
  output logic                       done,
  output logic                       timeout,
  output logic [31:0]                cycle_cnt,
  output logic [2:0]                 dbg_state
);

  import cpu_run_pkg::*;

  localparam int TW  = ADDR_W + 2*DATA_W + 1;
  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam logic [RCW-1:0]     RST_LOAD  = RCW'(RST_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] TMO_LAST  = CYCLE_W'(TIMEOUT_CYCLES - 1);

  run_state_t         r_state;
  run_state_t         w_next;
  logic               w_start_run;
  logic [RCW-1:0]     r_rst_cnt;
  logic [CYCLE_W-1:0] r_cycle_cnt;

  always_comb begin
    w_next      = r_state;
    w_start_run = 1'b0;
    case (r_state)
      IDLE, HALTED, TIMEOUT: begin
        if (start) begin
          w_next      = RST;
          w_start_run = 1'b1;
        end
      end
      RST: begin
        if (r_rst_cnt == '0) w_next = RUN;
      end
      RUN: begin
        // Halt wins over the watchdog when both land on the same cycle.
        if (cpu_halt)                      w_next = HALTED;
        else if (r_cycle_cnt == TMO_LAST)  w_next = TIMEOUT;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rst_cnt   <= '0;
      r_cycle_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_run) begin
        r_rst_cnt   <= RST_LOAD;
        r_cycle_cnt <= '0;
      end else begin
        if (r_state == RST && r_rst_cnt != '0)
          r_rst_cnt <= r_rst_cnt - RCW'(1);
        if (r_state == RUN && r_cycle_cnt != '1)
          r_cycle_cnt <= r_cycle_cnt + CYCLE_W'(1);
      end
    end
  end

  assign cpu_reset = (r_state != RUN);
  assign running   = (r_state == RST) || (r_state == RUN);
  assign done      = (r_state == HALTED);
  assign timeout   = (r_state == TIMEOUT);
  assign cycle_cnt = r_cycle_cnt;
  assign dbg_state = r_state;

`ifdef CPU_TRACE_EN
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic r_ovf;

  assign w_push = (r_state == RUN) && cpu_retire;
  assign w_pop  = !w_empty && trace_ready;

  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (TW)
  ) u_trace_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (w_start_run),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({cpu_ip, cpu_ir, cpu_ac, cpu_we}),
    .o_rdata (trace_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset || w_start_run) r_ovf <= 1'b0;
    else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
  end

  assign trace_valid = !w_empty;
  assign trace_ovf   = r_ovf;
`else
  logic w_unused;
  assign w_unused    = ^{trace_ready, cpu_retire, cpu_ip, cpu_ir, cpu_ac, cpu_we};
  assign trace_valid = 1'b0;
  assign trace_data  = '0;
  assign trace_ovf   = 1'b0;
`endif

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run controller that replaces the hand-written clock/reset/timeout harness around CPU.
- Sequences the CPU reset for a parametrised number of cycles.
- Runs the CPU until it halts or a watchdog cycle budget expires.
- Captures a per-instruction trace (IP, IR, AC, write-enable) into a drainable FIFO.
- Sits between the top level/bench and the CPU instance.

Parameters:
ADDR_W, 8, width of CPU IP.
DATA_W, 16, width of CPU IR and AC.
RST_CYCLES, 2, cycles cpu_reset is held high after start (must be >=1).
TIMEOUT_CYCLES, 5000, RUN-state cycle budget before watchdog fires (>=1).
TRACE_DEPTH, 16, trace FIFO entries (power of two, >=2).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-low; clears all state.
start  in  1  one-cycle pulse; begins a run from IDLE, HALTED or TIMEOUT.
cpu_reset  out  1  active-high reset driven into CPU.
cpu_ip  in  ADDR_W  CPU instruction pointer.
cpu_ir  in  DATA_W  CPU instruction register.
cpu_ac  in  DATA_W  CPU accumulator.
cpu_we  in  1  CPU memory write enable.
cpu_retire  in  1  one-cycle strobe at instruction completion.
cpu_halt  in  1  level, high when CPU executed HLT.
trace_valid  out  1  FIFO non-empty.
trace_ready  in  1  consumer accepts head entry.
trace_data  out  ADDR_W+2*DATA_W+1  {ip, ir, ac, we} of head entry.
trace_ovf  out  1  sticky: a retire was dropped because FIFO full.
running  out  1  high in RST and RUN states.
done  out  1  high in HALTED.
timeout  out  1  high in TIMEOUT.
cycle_cnt  out  32  RUN cycles elapsed in current/last run.

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE, cpu_reset=1, FIFO empty.
  - trace_valid=0, trace_ovf=0, done=0, timeout=0, running=0, cycle_cnt=0.
- FSM states: IDLE, RST, RUN, HALTED, TIMEOUT.
- IDLE: cpu_reset=1. On start -> RST; rst counter loads RST_CYCLES-1; cycle_cnt, trace_ovf and FIFO are cleared.
- RST: cpu_reset=1 for exactly RST_CYCLES cycles, then -> RUN. start is ignored.
- RUN: cpu_reset=0; cycle_cnt increments every cycle, saturating at 2^32-1.
  - If cpu_halt=1 -> HALTED. Halt is checked before timeout.
  - Else if cycle_cnt==TIMEOUT_CYCLES-1 -> TIMEOUT.
  - start is ignored.
- HALTED / TIMEOUT: cpu_reset=1 (CPU frozen); cycle_cnt holds; FIFO remains drainable. start -> RST, same clearing as from IDLE.
- Outputs are registered from state. done/timeout assert the cycle after the transition edge.
- Trace push: in RUN when cpu_retire=1.
  - Entry is {cpu_ip, cpu_ir, cpu_ac, cpu_we} sampled that edge.
  - If FIFO is full and no pop occurs the same cycle, the entry is dropped and trace_ovf is set.
- Trace pop: when trace_valid && trace_ready.
- Simultaneous push and pop on a full FIFO: both happen and no overflow is flagged.
- Simultaneous push and pop on an empty FIFO: push only; data becomes visible next cycle (no bypass).
- Read/write pointers are log2(TRACE_DEPTH)+1 bits; full/empty come from MSB compare. Wrap is natural.
- A retire in the same cycle as the halt transition is still captured.
- reset asserted mid-run returns to IDLE next edge and discards FIFO contents.

Optional Feature:
CPU_TRACE_EN
- Defined: trace FIFO and trace_ovf logic present as above.
- Undefined: no FIFO storage. trace_valid=0, trace_data=0, trace_ovf=0 constantly. trace_ready and cpu_retire are ignored. FSM and counters are unchanged.

Decomposition:
- Package cpu_run_pkg holds:
  - typedef enum logic [2:0] run_state_t {IDLE, RST, RUN, HALTED, TIMEOUT};
  - the packed trace_entry_t struct, parametrised via package localparams defaults matching ADDR_W/DATA_W;
  - localparam CYCLE_W=32.
- One sub-module: trace_fifo (sync FIFO, DEPTH/WIDTH params, push/pop/full/empty, synchronous clear), instantiated only under CPU_TRACE_EN.

Test Plan:
1. Reset low 2 cycles, then high, no start -> cpu_reset=1, running=0, trace_valid=0, state IDLE held for 20 cycles.
2. start pulse, RST_CYCLES=2 -> cpu_reset high exactly 2 cycles after start edge, then 0; running=1.
3. Model CPU retires 5 instructions (ip=0..4), then raises cpu_halt -> done=1, cpu_reset=1, 5 entries drained in order with ip 0..4; no trace_ovf.
4. TIMEOUT_CYCLES=100, cpu_halt never set -> timeout=1 after 100 RUN cycles, cycle_cnt=100; second start restarts with cycle_cnt=0.
5. TRACE_DEPTH=4, trace_ready=0, 6 retires -> 4 entries kept (first 4), trace_ovf=1. Repeat with trace_ready=1 on the full-FIFO cycle -> no overflow.
6. reset driven low during RUN with 3 FIFO entries -> next edge: IDLE, trace_valid=0, cycle_cnt=0, cpu_reset=1.
